mc_cmd_framer: RTL and testbench
================================

MC_CMD_FRAMER -- requirements
Module: mc_cmd_framer

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 8, meaning the word prefetch depth (power of two, 4..16).
REQ-002 The block SHALL have these ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_action  in  3  MC action code
cmd_size  in  2  MC size code (00=4, 01=8, 10=16, 11=32)
word_valid  in  1  operand word offered
word_data  in  32  operand word
word_ready  out  1  word accepted when high with word_valid
in_valid  out  1  to MC
in_data  out  32  to MC
size  out  2  to MC
action  out  3  to MC
mc_out_valid  in  1  from MC out_valid
busy  out  1  state != IDLE
err_underrun  out  1  sticky
err_action  out  1  sticky
err_timeout  out  1  sticky; tied 0 without MC_FRAMER_TIMEOUT_EN

Function
REQ-003 The FSM SHALL have states IDLE, FILL, BURST, WAIT_OUT and WAIT_END.
REQ-004 cmd_ready SHALL equal (state==IDLE); a command is accepted on a cycle where cmd_valid and cmd_ready are both high.
REQ-005 On accept, the burst length N SHALL be LEN*LEN for actions 100/101/110 and 1 for 000/001/010/011. For 100, the new size SHALL be used and LEN updated (4/8/16/32); otherwise the stored LEN is used.
REQ-006 Action 111 SHALL set err_action, produce no MC activity, and keep state IDLE.
REQ-007 N=1 actions SHALL go IDLE->BURST: one cycle of in_valid=1 with in_data=0, then WAIT_OUT.
REQ-008 Data actions SHALL go IDLE->FILL. word_ready SHALL be (FIFO not full) and (state is FILL or BURST) and (words accepted < N).
REQ-009 FILL->BURST SHALL occur when the FIFO holds min(N, FIFO_DEPTH) words.
REQ-010 In BURST, each cycle the FIFO is non-empty SHALL pop one word: in_valid=1, in_data=word, size/action = command values, all registered (1-cycle latency from pop decision).
REQ-011 An empty FIFO in BURST before N words have been issued SHALL drive in_valid=0 for that cycle and set err_underrun; the burst resumes when data arrives.
REQ-012 After the Nth word, state SHALL go to WAIT_OUT, with in_valid, in_data, size and action driven 0 from the next cycle; in_valid is never high outside BURST.
REQ-013 WAIT_OUT->WAIT_END SHALL occur on mc_out_valid=1; WAIT_END->IDLE SHALL occur on mc_out_valid=0. This guarantees at least one idle in_valid cycle between commands.
REQ-014 The issued-word counter SHALL be 11 bits wide (N up to 1024) with no wrap; the FIFO pointers wrap modulo FIFO_DEPTH. A simultaneous push and pop when full or empty SHALL be legal, and occupancy SHALL remain unchanged.
REQ-015 Sticky errors SHALL clear only on reset.

Reset
REQ-016 While rst=1 the block SHALL asynchronously force state=IDLE, LEN=4, FIFO empty, counters 0, and in_valid/in_data/size/action/err_* = 0, busy=0 and word_ready=0; cmd_ready=1.
REQ-017 A reset asserted mid-burst SHALL abort immediately, with no further in_valid after rst deasserts.

Configuration
REQ-018 With macro MC_FRAMER_TIMEOUT_EN defined, a 16-bit watchdog SHALL count cycles in WAIT_OUT. At 65535 it SHALL set err_timeout and force IDLE. Without the macro there is no watchdog, WAIT_OUT waits indefinitely, and err_timeout=0.

Verification
REQ-019 Setup size=00 with 16 contiguous words 1..16 -> in_valid high for exactly 16 consecutive cycles, in_data 1..16, action=100, size=00; mc_out_valid pulse then drop -> busy=0.
REQ-020 Transpose (010) after a size-01 setup -> single in_valid cycle, in_data=0, action=010, N=1; cmd_ready=0 until mc_out_valid falls.
REQ-021 Addition after a size-01 setup, word_valid gap of 3 cycles after word 20 -> in_valid low for those cycles, err_underrun=1, 64 words total issued.
REQ-022 cmd_action=111 -> err_action=1, in_valid stays 0, cmd_ready stays 1.
REQ-023 rst pulse during BURST word 5 of 16 -> all outputs 0 asynchronously, LEN=4, no in_valid afterwards until a new command.
REQ-024 MC_FRAMER_TIMEOUT_EN defined, mc_out_valid held 0 after a trace command -> err_timeout=1 and busy=0 at 65535 WAIT_OUT cycles.

Source files
------------

// File: rtl/mc_cmd_framer.sv
// Command framer for the matrix coprocessor: accepts commands, prefetches operand
// words and streams them as a registered burst. Watchdog enabled by MC_FRAMER_TIMEOUT_EN.
//   state    | meaning
//   IDLE     | ready for a command
//   FILL     | prefetching min(N, FIFO_DEPTH) words
//   BURST    | issuing N words (or one zero word for N=1 actions)
//   WAIT_OUT | waiting for MC out_valid to rise
//   WAIT_END | waiting for MC out_valid to fall
module mc_cmd_framer #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_action,
  input  logic [1:0]  cmd_size,
  input  logic        word_valid,
  input  logic [31:0] word_data,
  output logic        word_ready,
  output logic        in_valid,
  output logic [31:0] in_data,
  output logic [1:0]  size,
  output logic [2:0]  action,
  input  logic        mc_out_valid,
  output logic        busy,
  output logic        err_underrun,
  output logic        err_action,
  output logic        err_timeout
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_BURST, S_WAIT_OUT, S_WAIT_END} state_t;
  state_t state_q, state_d;

  logic [1:0]    len_q, len_d;        // LEN = 4 << len_q
  logic [2:0]    act_q, act_d;
  logic [10:0]   n_q, n_d;
  logic [10:0]   acc_q, acc_d;
  logic [10:0]   iss_q, iss_d;
  logic          data_cmd_q, data_cmd_d;

  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q, fill_tgt;

  logic          in_valid_q, in_valid_d;
  logic [31:0]   in_data_q, in_data_d;
  logic [1:0]    size_q, size_d;
  logic [2:0]    action_q, action_d;
  logic          err_underrun_q, err_action_q;

  logic accept, push, pop, issue, underrun, fifo_full, fifo_empty, wdog_hit;

  function automatic logic [10:0] burst_len(input logic [1:0] code);
    burst_len = 11'd16 << {code, 1'b0};
  endfunction

  assign accept     = cmd_valid && cmd_ready;
  assign fifo_full  = (cnt_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign fill_tgt   = (n_q < 11'(FIFO_DEPTH)) ? n_q[CW-1:0] : CW'(FIFO_DEPTH);
  assign push       = word_valid && word_ready;

  // State register and all sequential state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      len_q          <= 2'b00;
      act_q          <= 3'b000;
      n_q            <= 11'd0;
      acc_q          <= 11'd0;
      iss_q          <= 11'd0;
      data_cmd_q     <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      cnt_q          <= '0;
      in_valid_q     <= 1'b0;
      in_data_q      <= 32'd0;
      size_q         <= 2'b00;
      action_q       <= 3'b000;
      err_underrun_q <= 1'b0;
      err_action_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      act_q          <= act_d;
      n_q            <= n_d;
      acc_q          <= acc_d;
      iss_q          <= iss_d;
      data_cmd_q     <= data_cmd_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q          <= cnt_q + CW'(push) - CW'(pop);
      in_valid_q     <= in_valid_d;
      in_data_q      <= in_data_d;
      size_q         <= size_d;
      action_q       <= action_d;
      err_underrun_q <= err_underrun_q | underrun;
      err_action_q   <= err_action_q | (accept && (cmd_action == 3'b111));
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= word_data;
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    act_d      = act_q;
    n_d        = n_q;
    data_cmd_d = data_cmd_q;
    acc_d      = acc_q + 11'(push);
    iss_d      = iss_q + 11'(issue);
    case (state_q)
      S_IDLE: begin
        if (accept && (cmd_action != 3'b111)) begin
          act_d = cmd_action;
          acc_d = 11'd0;
          iss_d = 11'd0;
          if (cmd_action[2]) begin
            data_cmd_d = 1'b1;
            if (cmd_action == 3'b100) begin
              len_d = cmd_size;
              n_d   = burst_len(cmd_size);
            end else begin
              n_d   = burst_len(len_q);
            end
            state_d = S_FILL;
          end else begin
            data_cmd_d = 1'b0;
            n_d        = 11'd1;
            state_d    = S_BURST;
          end
        end
      end
      S_FILL:     if (cnt_q == fill_tgt) state_d = S_BURST;
      S_BURST:    if (iss_q == n_q) state_d = S_WAIT_OUT;
      S_WAIT_OUT: begin
        if (wdog_hit)          state_d = S_IDLE;
        else if (mc_out_valid) state_d = S_WAIT_END;
      end
      S_WAIT_END: if (!mc_out_valid) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Output logic: issue decision and registered MC-side values
  always_comb begin
    issue      = 1'b0;
    underrun   = 1'b0;
    pop        = 1'b0;
    in_valid_d = 1'b0;
    in_data_d  = 32'd0;
    size_d     = 2'b00;
    action_d   = 3'b000;
    if ((state_q == S_BURST) && (iss_q < n_q)) begin
      if (!data_cmd_q || !fifo_empty) issue = 1'b1;
      else                            underrun = 1'b1;
    end
    pop = issue && data_cmd_q;
    if (issue) begin
      in_valid_d = 1'b1;
      in_data_d  = data_cmd_q ? mem_q[rd_ptr_q] : 32'd0;
      size_d     = len_q;
      action_d   = act_q;
    end
  end

  assign cmd_ready    = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign word_ready   = data_cmd_q && !fifo_full && (acc_q < n_q) &&
                        ((state_q == S_FILL) || (state_q == S_BURST));
  assign in_valid     = in_valid_q;
  assign in_data      = in_data_q;
  assign size         = size_q;
  assign action       = action_q;
  assign err_underrun = err_underrun_q;
  assign err_action   = err_action_q;

`ifdef MC_FRAMER_TIMEOUT_EN
  logic [15:0] wdog_q;
  logic        err_timeout_q;

  assign wdog_hit = (state_q == S_WAIT_OUT) && (wdog_q == 16'hFFFF) && !mc_out_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_q        <= 16'd0;
      err_timeout_q <= 1'b0;
    end else begin
      wdog_q        <= (state_q == S_WAIT_OUT) ? wdog_q + 16'd1 : 16'd0;
      err_timeout_q <= err_timeout_q | wdog_hit;
    end
  end

  assign err_timeout = err_timeout_q;
`else
  assign wdog_hit    = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mc_cmd_framer.sv
// Self-checking bench for mc_cmd_framer: directed scenarios plus randomized
// commands checked against a queue-based reference of accepted words.
`timescale 1ns/1ps
module tb_mc_cmd_framer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_action = 3'd0;
  logic [1:0]  cmd_size = 2'd0;
  logic        word_valid = 1'b0;
  logic [31:0] word_data = 32'd0;
  logic        word_ready;
  logic        in_valid;
  logic [31:0] in_data;
  logic [1:0]  size;
  logic [2:0]  action;
  logic        mc_out_valid = 1'b0;
  logic        busy, err_underrun, err_action, err_timeout;

  int n_checks = 0;
  int n_pass = 0;

  logic [31:0] acc_words[$];
  logic [31:0] out_words[$];
  logic [1:0]  out_size[$];
  logic [2:0]  out_act[$];
  int   gap_cycles, first_cyc, last_cyc;
  bit   timed_out, stray_valid;
  logic cmd_seen_ready;

  always #5 clk = ~clk;

  mc_cmd_framer #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_action(cmd_action), .cmd_size(cmd_size),
    .word_valid(word_valid), .word_data(word_data), .word_ready(word_ready),
    .in_valid(in_valid), .in_data(in_data), .size(size), .action(action),
    .mc_out_valid(mc_out_valid), .busy(busy),
    .err_underrun(err_underrun), .err_action(err_action), .err_timeout(err_timeout)
  );

  task automatic do_reset();
    rst = 1'b1; cmd_valid = 0; word_valid = 0; mc_out_valid = 0;
    cmd_action = 0; cmd_size = 0; word_data = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Issues one command and feeds words; records the accepted words and what reaches the MC.
  task automatic run_cmd(input logic [2:0] act, input logic [1:0] sz, input int n_exp,
                         input int gap_at, input int gap_len, input bit rnd, input int abort_at);
    int  gap_left;
    bit  gap_done, done;
    acc_words.delete(); out_words.delete(); out_size.delete(); out_act.delete();
    gap_cycles = 0; first_cyc = -1; last_cyc = -1; timed_out = 0; stray_valid = 0;
    gap_left = 0; gap_done = 0; done = 0;
    cmd_valid = 1'b1; cmd_action = act; cmd_size = sz;
    cmd_seen_ready = cmd_ready;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_action = 0; cmd_size = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (in_valid) begin
        out_words.push_back(in_data); out_size.push_back(size); out_act.push_back(action);
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end else if (out_words.size() > 0 && out_words.size() < n_exp) begin
        gap_cycles++;
      end
      if (cmd_ready && in_valid) stray_valid = 1;
      if (abort_at > 0 && out_words.size() == abort_at) return;
      if (out_words.size() >= n_exp && !in_valid) begin
        done = 1;
        break;
      end
      if (act[2] && out_words.size() < n_exp) begin
        if (gap_at > 0 && !gap_done && acc_words.size() == gap_at) begin
          gap_done = 1; gap_left = gap_len;
        end
        if (gap_left > 0) begin
          word_valid = 1'b0; gap_left--;
        end else begin
          word_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        word_data = rnd ? $urandom : 32'(acc_words.size() + 1);
      end else begin
        word_valid = 1'b0; word_data = 32'd0;
      end
      if (word_valid && word_ready) acc_words.push_back(word_data);
      @(negedge clk);
    end
    word_valid = 1'b0;
    timed_out = !done;
  endtask

  task automatic finish_cmd(output logic busy_mid, output logic rdy_mid, output logic busy_end);
    mc_out_valid = 1'b1;
    @(negedge clk);
    busy_mid = busy; rdy_mid = cmd_ready;
    mc_out_valid = 1'b0;
    @(negedge clk);
    busy_end = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (cmd_ready !== 1'b1) $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); else n_pass++;
    n_checks++; if (word_ready !== 1'b0) $display("FAIL rst_word_ready: got %b want 0", word_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (in_valid !== 1'b0) $display("FAIL rst_in_valid: got %b want 0", in_valid); else n_pass++;
    n_checks++; if (in_data !== 32'd0) $display("FAIL rst_in_data: got %h want 0", in_data); else n_pass++;
    n_checks++; if ({size, action} !== 5'd0) $display("FAIL rst_size_action: got %b want 0", {size, action}); else n_pass++;
    n_checks++; if ({err_underrun, err_action, err_timeout} !== 3'b000)
      $display("FAIL rst_errors: got %b want 000", {err_underrun, err_action, err_timeout}); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_setup_burst();
    int bad;
    logic bm, rm, be;
    do_reset();
    run_cmd(3'b100, 2'b00, 16, 0, 0, 0, 0);
    n_checks++; if (cmd_seen_ready !== 1'b1) $display("FAIL setup_cmd_ready: got %b want 1", cmd_seen_ready); else n_pass++;
    n_checks++; if (timed_out !== 1'b0) $display("FAIL setup_timeout: got %b want 0", timed_out); else n_pass++;
    n_checks++; if (out_words.size() != 16) $display("FAIL setup_count: got %0d want 16", out_words.size()); else n_pass++;
    bad = 0;
    foreach (out_words[i])
      if (out_words[i] !== 32'(i + 1) || out_act[i] !== 3'b100 || out_size[i] !== 2'b00) bad++;
    n_checks++; if (bad != 0) $display("FAIL setup_words: got %0d bad words want 0", bad); else n_pass++;
    n_checks++; if (last_cyc - first_cyc + 1 != 16)
      $display("FAIL setup_contiguous: got span %0d want 16", last_cyc - first_cyc + 1); else n_pass++;
    n_checks++; if (acc_words.size() != 16) $display("FAIL setup_accepted: got %0d want 16", acc_words.size()); else n_pass++;
    n_checks++; if (err_underrun !== 1'b0) $display("FAIL setup_underrun: got %b want 0", err_underrun); else n_pass++;
    n_checks++; if (stray_valid !== 1'b0) $display("FAIL setup_stray: got %b want 0", stray_valid); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL setup_busy_wait: got %b want 1", busy); else n_pass++;
    finish_cmd(bm, rm, be);
    n_checks++; if (be !== 1'b0) $display("FAIL setup_busy_end: got %b want 0", be); else n_pass++;
    n_checks++; if ({in_valid, in_data, size, action} !== 38'd0)
      $display("FAIL setup_idle_outputs: got %h want 0", {in_valid, in_data, size, action}); else n_pass++;
  endtask

  task automatic test_transpose();
    logic bm, rm, be;
    do_reset();
    run_cmd(3'b100, 2'b01, 64, 0, 0, 0, 0);
    finish_cmd(bm, rm, be);
    run_cmd(3'b010, 2'b00, 1, 0, 0, 0, 0);
    n_checks++; if (out_words.size() != 1) $display("FAIL tr_count: got %0d want 1", out_words.size()); else n_pass++;
    if (out_words.size() >= 1) begin
      n_checks++; if (out_words[0] !== 32'd0) $display("FAIL tr_data: got %h want 0", out_words[0]); else n_pass++;
      n_checks++; if (out_act[0] !== 3'b010) $display("FAIL tr_action: got %b want 010", out_act[0]); else n_pass++;
      n_checks++; if (out_size[0] !== 2'b01) $display("FAIL tr_size: got %b want 01", out_size[0]); else n_pass++;
    end
    n_checks++; if (acc_words.size() != 0) $display("FAIL tr_no_words: got %0d want 0", acc_words.size()); else n_pass++;
    n_checks++; if (cmd_ready !== 1'b0) $display("FAIL tr_ready_wait: got %b want 0", cmd_ready); else n_pass++;
    finish_cmd(bm, rm, be);
    n_checks++; if (rm !== 1'b0) $display("FAIL tr_ready_mid: got %b want 0", rm); else n_pass++;
    n_checks++; if (cmd_ready !== 1'b1) $display("FAIL tr_ready_end: got %b want 1", cmd_ready); else n_pass++;
  endtask

  task automatic test_underrun();
    int bad;
    logic bm, rm, be;
    do_reset();
    run_cmd(3'b100, 2'b01, 64, 0, 0, 0, 0);
    finish_cmd(bm, rm, be);
    n_checks++; if (err_underrun !== 1'b0) $display("FAIL ur_before: got %b want 0", err_underrun); else n_pass++;
    run_cmd(3'b101, 2'b00, 64, 20, 3, 0, 0);
    n_checks++; if (out_words.size() != 64) $display("FAIL ur_count: got %0d want 64", out_words.size()); else n_pass++;
    bad = 0;
    foreach (out_words[i])
      if (out_words[i] !== 32'(i + 1) || out_act[i] !== 3'b101 || out_size[i] !== 2'b01) bad++;
    n_checks++; if (bad != 0) $display("FAIL ur_words: got %0d bad words want 0", bad); else n_pass++;
    n_checks++; if (gap_cycles == 0) $display("FAIL ur_gap: got %0d idle cycles want >0", gap_cycles); else n_pass++;
    n_checks++; if (err_underrun !== 1'b1) $display("FAIL ur_flag: got %b want 1", err_underrun); else n_pass++;
    finish_cmd(bm, rm, be);
    n_checks++; if (err_underrun !== 1'b1) $display("FAIL ur_sticky: got %b want 1", err_underrun); else n_pass++;
  endtask

  task automatic test_bad_action();
    int nv;
    do_reset();
    cmd_valid = 1'b1; cmd_action = 3'b111; cmd_size = 2'b10;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_action = 0; cmd_size = 0;
    nv = 0;
    for (int i = 0; i < 6; i++) begin
      if (in_valid || !cmd_ready || busy) nv++;
      @(negedge clk);
    end
    n_checks++; if (err_action !== 1'b1) $display("FAIL act_err: got %b want 1", err_action); else n_pass++;
    n_checks++; if (nv != 0) $display("FAIL act_quiet: got %0d active cycles want 0", nv); else n_pass++;
    // LEN must be untouched by the rejected command
    run_cmd(3'b001, 2'b00, 1, 0, 0, 0, 0);
    n_checks++; if (out_size.size() != 1 || out_size[0] !== 2'b00)
      $display("FAIL act_len: got %0d entries want size 00", out_size.size()); else n_pass++;
    do_reset();
  endtask

  task automatic test_reset_mid_burst();
    int nv;
    logic [1:0] sz;
    logic bm, rm, be;
    for (int k = 0; k < 2; k++) begin
      sz = (k == 0) ? 2'b00 : 2'b10;
      do_reset();
      run_cmd(3'b100, sz, (k == 0) ? 16 : 256, 0, 0, 0, 5);
      n_checks++; if (out_words.size() != 5) $display("FAIL abort_reached: got %0d want 5", out_words.size()); else n_pass++;
      #2 rst = 1'b1;
      #1;
      n_checks++; if ({in_valid, in_data, size, action} !== 38'd0)
        $display("FAIL abort_outputs: got %h want 0", {in_valid, in_data, size, action}); else n_pass++;
      n_checks++; if ({busy, word_ready, cmd_ready} !== 3'b001)
        $display("FAIL abort_ctrl: got %b want 001", {busy, word_ready, cmd_ready}); else n_pass++;
      word_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      nv = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (in_valid || busy) nv++;
      end
      n_checks++; if (nv != 0) $display("FAIL abort_quiet: got %0d active cycles want 0", nv); else n_pass++;
      run_cmd(3'b011, 2'b00, 1, 0, 0, 0, 0);
      n_checks++; if (out_size.size() != 1 || out_size[0] !== 2'b00)
        $display("FAIL abort_len: got %0d entries want size 00", out_size.size()); else n_pass++;
      finish_cmd(bm, rm, be);
    end
  endtask

  task automatic test_random();
    int         n, len_m, bad;
    logic [2:0] act;
    logic [1:0] sz;
    logic       exp_und;
    logic bm, rm, be;
    do_reset();
    len_m = 0; exp_und = 1'b0;
    for (int t = 0; t < 8; t++) begin
      act = 3'($urandom_range(0, 6));
      sz  = 2'($urandom_range(0, 3));
      if (act == 3'b100) len_m = int'(sz);
      n = act[2] ? (4 << len_m) * (4 << len_m) : 1;
      run_cmd(act, sz, n, 0, 0, 1, 0);
      n_checks++; if (timed_out !== 1'b0) $display("FAIL rnd_timeout: act %b got %b want 0", act, timed_out); else n_pass++;
      n_checks++; if (out_words.size() != n) $display("FAIL rnd_count: act %b got %0d want %0d", act, out_words.size(), n); else n_pass++;
      n_checks++; if (acc_words.size() != (act[2] ? n : 0))
        $display("FAIL rnd_accepted: act %b got %0d want %0d", act, acc_words.size(), act[2] ? n : 0); else n_pass++;
      bad = 0;
      foreach (out_words[i]) begin
        if (out_act[i] !== act || out_size[i] !== 2'(len_m)) bad++;
        else if (act[2] && (i >= acc_words.size() || out_words[i] !== acc_words[i])) bad++;
        else if (!act[2] && out_words[i] !== 32'd0) bad++;
      end
      n_checks++; if (bad != 0) $display("FAIL rnd_words: act %b got %0d bad words want 0", act, bad); else n_pass++;
      exp_und = exp_und | (gap_cycles > 0);
      n_checks++; if (err_underrun !== exp_und) $display("FAIL rnd_underrun: got %b want %b", err_underrun, exp_und); else n_pass++;
      n_checks++; if (stray_valid !== 1'b0) $display("FAIL rnd_stray: got %b want 0", stray_valid); else n_pass++;
      finish_cmd(bm, rm, be);
      n_checks++; if (be !== 1'b0) $display("FAIL rnd_busy_end: got %b want 0", be); else n_pass++;
    end
  endtask

  task automatic test_timeout();
    int cnt, nv;
    do_reset();
    run_cmd(3'b000, 2'b00, 1, 0, 0, 0, 0);
    mc_out_valid = 1'b0;
`ifdef MC_FRAMER_TIMEOUT_EN
    cnt = 0;
    while (busy && cnt < 70000) begin
      @(negedge clk);
      cnt++;
    end
    n_checks++; if (busy !== 1'b0) $display("FAIL to_busy: got %b want 0 after %0d cycles", busy, cnt); else n_pass++;
    n_checks++; if (err_timeout !== 1'b1) $display("FAIL to_flag: got %b want 1", err_timeout); else n_pass++;
    n_checks++; if (cnt < 65530 || cnt > 65540) $display("FAIL to_cycles: got %0d want about 65536", cnt); else n_pass++;
    nv = 0;
`else
    nv = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_valid) nv++;
    end
    cnt = 300;
    n_checks++; if (busy !== 1'b1) $display("FAIL to_busy: got %b want 1 after %0d cycles", busy, cnt); else n_pass++;
    n_checks++; if (err_timeout !== 1'b0) $display("FAIL to_flag: got %b want 0", err_timeout); else n_pass++;
    n_checks++; if (cmd_ready !== 1'b0) $display("FAIL to_ready: got %b want 0", cmd_ready); else n_pass++;
`endif
    n_checks++; if (nv != 0) $display("FAIL to_quiet: got %0d in_valid cycles want 0", nv); else n_pass++;
    do_reset();
  endtask

  initial begin
    test_reset();
    test_setup_burst();
    test_transpose();
    test_underrun();
    test_bad_action();
    test_reset_mid_burst();
    test_random();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
